// File: rtl/carregador_programa.sv
// Program loader: pairs 5-bit stream words into {opcode, operand} entries and
// writes them to the CPU instruction memory, holding the CPU in reset meanwhile.
module carregador_programa #(
  parameter int WIDTH  = 5,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_word,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_op,
  output logic [WIDTH-1:0]  mem_dado,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              erro,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {OCIOSO, RECEBE_OP, RECEBE_DADO, ESCREVE, FIM} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [WIDTH-1:0]  op_q;
  logic              last_q;
  logic              ovf_q;
  logic              we_q;
  logic              xfer;
  logic [ADDR_W:0]   count_next;

  assign xfer       = in_valid && in_ready;
  assign count_next = count + 1'b1;
  // A reset landing in the write cycle suppresses the strobe the memory would sample.
  assign mem_we     = we_q && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= OCIOSO;
      in_ready <= 1'b0;
      we_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      erro     <= 1'b0;
      cpu_hold <= 1'b1;
      mem_addr <= '0;
      mem_op   <= '0;
      mem_dado <= '0;
      count    <= '0;
      ovf_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state)
        OCIOSO, FIM: begin
          if (start) begin
            state    <= RECEBE_OP;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            erro     <= 1'b0;
            cpu_hold <= 1'b1;
            count    <= '0;
            mem_addr <= '0;
            ovf_q    <= 1'b0;
          end
        end
        RECEBE_OP: begin
          if (xfer) begin
            // A lone opcode marked last, or any word after memory is full, is an error.
            if (in_last || ovf_q) begin
              state    <= FIM;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              erro     <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              op_q  <= in_word;
              state <= RECEBE_DADO;
            end
          end
        end
        RECEBE_DADO: begin
          if (xfer) begin
            last_q   <= in_last;
            mem_addr <= count[ADDR_W-1:0];
            mem_op   <= op_q;
            mem_dado <= in_word;
            we_q     <= 1'b1;
            in_ready <= 1'b0;
            state    <= ESCREVE;
          end
        end
        ESCREVE: begin
          count <= count_next;
          if (last_q) begin
            state    <= FIM;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= erro;
          end else begin
            state    <= RECEBE_OP;
            in_ready <= 1'b1;
            if (count_next == DEPTH_C) ovf_q <= 1'b1;
          end
        end
        default: state <= OCIOSO;
      endcase
    end
  end

endmodule

// File: doc/carregador_programa.md
Name: carregador_programa

Overview:
- Program loader: the write side of the CPU's instruction memory, which the CPU otherwise only reads.
- Accepts a stream of 5-bit words over a valid/ready handshake.
- Pairs consecutive words into {opcode, operand} entries and writes them into the instruction memory at sequential addresses.
- Holds the CPU controller in reset while loading.

Parameters:
WIDTH, 5, width of opcode, operand and stream words
DEPTH, 16, number of instruction entries in memory
ADDR_W, 4, memory address width (log2 DEPTH)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin a new load at address 0
in_valid  input  1  stream word valid
in_ready  output  1  loader can accept a word this cycle
in_word  input  WIDTH  stream word (opcode or operand)
in_last  input  1  marks final word of program; qualified by in_valid
mem_we  output  1  one-cycle memory write strobe
mem_addr  output  ADDR_W  memory write address
mem_op  output  WIDTH  opcode written to entry
mem_dado  output  WIDTH  operand written to entry
cpu_hold  output  1  keeps CPU controller/counter held while high
busy  output  1  load in progress
done  output  1  load finished; sticky until start or reset
erro  output  1  truncated or overflowed program; sticky until start or reset
count  output  ADDR_W+1  number of entries written, saturates at DEPTH

Behaviour:
- Reset values:
  - State OCIOSO.
  - in_ready, mem_we, busy, done, erro = 0.
  - mem_addr, mem_op, mem_dado, count = 0.
  - cpu_hold = 1, so the CPU never runs an unloaded memory.
- States: OCIOSO, RECEBE_OP, RECEBE_DADO, ESCREVE, FIM.
- A transfer occurs when in_valid && in_ready are high on a rising edge.
- OCIOSO:
  - in_ready=0.
  - start -> RECEBE_OP; clears count, mem_addr, done, erro; busy=1; cpu_hold=1.
- RECEBE_OP:
  - in_ready=1.
  - Transfer latches in_word into op register, then -> RECEBE_DADO.
  - Transfer with in_last=1 is a truncated entry: no write, erro=1, -> FIM.
- RECEBE_DADO:
  - in_ready=1.
  - Transfer latches in_word into operand register and latches in_last, then -> ESCREVE.
- ESCREVE:
  - in_ready=0.
  - mem_we=1 for exactly this cycle; mem_addr=count[ADDR_W-1:0]; mem_op/mem_dado are the latched values.
  - Next edge: count+1.
  - If latched last=1 -> FIM.
  - Else if count+1 == DEPTH -> RECEBE_OP in overflow mode: no further writes; any subsequent transfer sets erro=1 and -> FIM.
  - Else -> RECEBE_OP.
- Latency: write strobe occurs 1 cycle after the operand transfer. Maximum throughput is 2 words per 3 cycles.
- FIM:
  - in_ready=0, busy=0, done=1.
  - cpu_hold=0 only if erro=0; with erro=1, cpu_hold stays 1.
  - start -> restarts a load (same as from OCIOSO).
- start while busy is ignored.
- in_valid without in_ready: word is not consumed; the source must hold it.
- mem_addr never wraps. Entries beyond DEPTH are never written, and the address stays at DEPTH-1 after the last write.
- Reset mid-load: returns to OCIOSO on the next edge. A write pending in ESCREVE is not issued. Memory contents already written are left as they are.
- Simultaneous reset and start: reset wins.
- Outputs are registered. mem_op/mem_dado hold their last values outside ESCREVE.

Test Plan:
- Reset then idle: reset 2 cycles -> cpu_hold=1, in_ready=0, mem_we=0, count=0, done=0, erro=0.
- Two-entry load: start, then stream 5'h01,5'h07,5'h02,5'h1F(last) with in_valid held high -> mem_we pulses with (addr0,op01,dado07) and (addr1,op02,dado1F); count=2; done=1; cpu_hold=0; in_ready low in each ESCREVE cycle.
- Backpressure/gaps: same stream with in_valid toggling every other cycle -> identical writes, no duplicated or lost words.
- Truncated: start, send 5'h03 with in_last=1 -> no mem_we, erro=1, done=1, cpu_hold stays 1.
- Overflow: DEPTH=16 stream of 17 entries, last on the 17th operand -> exactly 16 writes at addr 0..15, count=16, erro=1, cpu_hold=1.
- Reset mid-load: assert reset in the ESCREVE cycle of entry 3 -> no write that cycle, state OCIOSO, count=0; a subsequent start plus one-entry load gives a clean write at addr0 and done=1.
